// File: rtl/sqrt8_pkg.sv
// Shared types and arithmetic for the sqrt8 result stage: entry layout and
// the remainder/consistency check applied to each operand/root pair.
package sqrt8_pkg;

    localparam int OPND_W = 8;
    localparam int ROOT_W = 4;
    localparam int REM_W  = 5;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic [REM_W-1:0]  rem;
        logic              exact;
        logic              err;
    } result_t;

    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic             exact;
        logic             err;
    } calc_t;

    // A consistent root satisfies 0 <= operand - root^2 <= 2*root.
    function automatic calc_t calc_result(input logic [OPND_W-1:0] operand,
                                          input logic [ROOT_W-1:0] root);
        logic [OPND_W-1:0] sq;
        logic [OPND_W:0]   diff;
        logic [OPND_W:0]   lim;
        calc_t             res;
        sq   = {4'd0, root} * {4'd0, root};
        diff = {1'b0, operand} - {1'b0, sq};
        lim  = {4'd0, root, 1'b0};
        res.err = diff[OPND_W] || (diff > lim);
        if (res.err) begin
            res.rem   = 5'd0;
            res.exact = 1'b0;
        end else begin
            res.rem   = diff[REM_W-1:0];
            res.exact = (diff == 9'd0);
        end
        return res;
    endfunction

endpackage

// File: rtl/sqrt8_result_fifo.sv
// DEPTH-entry synchronous FIFO of result entries; head is presented
// directly from storage and reads as zero while empty.
module sqrt8_result_fifo
    import sqrt8_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  result_t wdata,
    output result_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    result_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Head mux; zero while empty so downstream never sees stale data.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = '0;
        end
    end

    // Storage and pointers; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy is tracked separately from the pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sqrt8_result_stage.sv
// Consumer stage behind the 8-bit integer square root: checks each root,
// computes the remainder, buffers results and keeps saturating statistics.
module sqrt8_result_stage
    import sqrt8_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_operand,
    input  logic [ROOT_W-1:0] in_root,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] out_root,
    output logic [REM_W-1:0]  out_rem,
    output logic              out_exact,
    output logic              out_err,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  cnt_exact,
    output logic [CNT_W-1:0]  cnt_err
);

    calc_t            calc_s;
    result_t          entry_s;
    result_t          head_s;
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             pop_s;
    logic [CNT_W-1:0] cnt_exact_r;
    logic [CNT_W-1:0] cnt_err_r;

    // Result is computed at acceptance so the FIFO holds finished entries.
    always_comb begin
        calc_s        = calc_result(in_operand, in_root);
        entry_s       = '0;
        entry_s.root  = in_root;
        entry_s.rem   = calc_s.rem;
        entry_s.exact = calc_s.exact;
        entry_s.err   = calc_s.err;
    end

    assign in_ready  = !full_s;
    assign accept_s  = in_valid && !full_s;
    assign out_valid = !empty_s;
    assign pop_s     = !empty_s && out_ready;

    sqrt8_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept_s),
        .pop   (pop_s),
        .wdata (entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign out_root  = head_s.root;
    assign out_rem   = head_s.rem;
    assign out_exact = head_s.exact;
    assign out_err   = head_s.err;

    // Exact-square counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_exact_r <= '0;
        end else if (stat_clr) begin
            cnt_exact_r <= '0;
        end else if (accept_s && calc_s.exact && (cnt_exact_r != {CNT_W{1'b1}})) begin
            cnt_exact_r <= cnt_exact_r + CNT_W'(1);
        end else begin
            cnt_exact_r <= cnt_exact_r;
        end
    end

    // Inconsistent-root counter; same clear and saturation rules.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_err_r <= '0;
        end else if (stat_clr) begin
            cnt_err_r <= '0;
        end else if (accept_s && calc_s.err && (cnt_err_r != {CNT_W{1'b1}})) begin
            cnt_err_r <= cnt_err_r + CNT_W'(1);
        end else begin
            cnt_err_r <= cnt_err_r;
        end
    end

    assign cnt_exact = cnt_exact_r;
    assign cnt_err   = cnt_err_r;

endmodule

// File: tb/tb_sqrt8_result_stage.sv
// Self-checking bench for sqrt8_result_stage: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_sqrt8_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_operand;
    logic [3:0] in_root;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_root;
    logic [4:0] out_rem;
    logic       out_exact;
    logic       out_err;
    logic       stat_clr;
    logic [CNT_W-1:0] cnt_exact;
    logic [CNT_W-1:0] cnt_err;

    sqrt8_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_operand (in_operand),
        .in_root    (in_root),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_root   (out_root),
        .out_rem    (out_rem),
        .out_exact  (out_exact),
        .out_err    (out_err),
        .stat_clr   (stat_clr),
        .cnt_exact  (cnt_exact),
        .cnt_err    (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int root;
        int rem;
        bit exact;
        bit err;
    } ent_t;

    typedef struct {
        logic [7:0] operand;
        logic [3:0] root;
        int         rem;
        bit         exact;
        bit         err;
    } vec_t;

    ent_t q[$];
    int   m_ce;
    int   m_cr;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic ent_t model_calc(input int operand, input int root);
        ent_t e;
        int   d;
        d       = operand - root * root;
        e.root  = root;
        e.err   = (d < 0) || (d > 2 * root);
        e.rem   = e.err ? 0 : d;
        e.exact = !e.err && (d == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = '{root: 0, rem: 0, exact: 1'b0, err: 1'b0};
        if (q.size() > 0) h = q[0];
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        check("out_root",  32'(out_root),  32'(h.root));
        check("out_rem",   32'(out_rem),   32'(h.rem));
        check("out_exact", 32'(out_exact), 32'(h.exact));
        check("out_err",   32'(out_err),   32'(h.err));
        check("cnt_exact", 32'(cnt_exact), 32'(m_ce));
        check("cnt_err",   32'(cnt_err),   32'(m_cr));
    endtask

    // One clock: compare at negedge, advance model at the edge, return #1 after.
    task automatic step();
        bit   acc;
        bit   pp;
        ent_t e;
        @(negedge clk);
        check_model();
        if (!rst_n) begin
            q.delete();
            m_ce = 0;
            m_cr = 0;
        end else begin
            acc = in_valid && (q.size() < DEPTH);
            pp  = out_ready && (q.size() > 0);
            e   = model_calc(int'(in_operand), int'(in_root));
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (stat_clr) begin
                m_ce = 0;
                m_cr = 0;
            end else if (acc) begin
                if (e.exact && m_ce < CMAX) m_ce++;
                if (e.err && m_cr < CMAX) m_cr++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] op, input logic [3:0] rt);
        in_valid   = v;
        in_operand = op;
        in_root    = rt;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'hFF, 4'd15, 30, 1'b0, 1'b0};
        tbl[1] = '{8'h40, 4'd8,  0,  1'b1, 1'b0};
        tbl[2] = '{8'h10, 4'd5,  0,  1'b0, 1'b1};
        tbl[3] = '{8'h23, 4'd4,  0,  1'b0, 1'b1};
        tbl[4] = '{8'h00, 4'd0,  0,  1'b1, 1'b0};
        tbl[5] = '{8'h03, 4'd1,  2,  1'b0, 1'b0};
        tbl[6] = '{8'h04, 4'd1,  0,  1'b0, 1'b1};
        tbl[7] = '{8'hE1, 4'd15, 0,  1'b1, 1'b0};
        tbl[8] = '{8'h08, 4'd2,  4,  1'b0, 1'b0};
        tbl[9] = '{8'h09, 4'd2,  0,  1'b0, 1'b1};

        rst_n = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        drive(1'b0, 8'h00, 4'h0);
        q.delete(); m_ce = 0; m_cr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check_model();

        // Directed table: each pair appears exactly one cycle after acceptance.
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            drive(1'b1, tbl[i].operand, tbl[i].root);
            step();
            drive(1'b0, 8'hA5, 4'h3);
            check("tbl out_valid", 32'(out_valid), 32'd1);
            check("tbl out_root",  32'(out_root),  32'(tbl[i].root));
            check("tbl out_rem",   32'(out_rem),   32'(tbl[i].rem));
            check("tbl out_exact", 32'(out_exact), 32'(tbl[i].exact));
            check("tbl out_err",   32'(out_err),   32'(tbl[i].err));
            out_ready = 1'b1;
            step();
        end
        check("tbl cnt_exact", 32'(cnt_exact), 32'd3);
        check("tbl cnt_err",   32'(cnt_err),   32'd4);

        // Back-pressure: third back-to-back pair must be refused.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 4'd4); step();
        drive(1'b1, 8'h19, 4'd5); step();
        check("bp full in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h24, 4'd6); step();
        drive(1'b0, 8'h00, 4'd0);
        out_ready = 1'b1;
        check("bp head1 root", 32'(out_root), 32'd4);
        step();
        check("bp head2 root", 32'(out_root), 32'd5);
        step();
        check("bp drained valid", 32'(out_valid), 32'd0);
        check("bp in_ready back", 32'(in_ready),  32'd1);

        // Saturation of the exact counter, then clear against an increment.
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 8'h40, 4'd8);
            step();
        end
        drive(1'b0, 8'h00, 4'd0);
        check("sat cnt_exact", 32'(cnt_exact), 32'd255);
        drive(1'b1, 8'h31, 4'd7);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        drive(1'b0, 8'h00, 4'd0);
        check("clr wins cnt_exact", 32'(cnt_exact), 32'd0);
        step();

        // Reset while holding two entries discards them.
        out_ready = 1'b0;
        drive(1'b1, 8'h09, 4'd3); step();
        drive(1'b1, 8'h10, 4'd5); step();
        drive(1'b0, 8'h00, 4'd0);
        check("pre-rst full", 32'(in_ready), 32'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("rst out_valid",  32'(out_valid), 32'd0);
        check("rst in_ready",   32'(in_ready),  32'd1);
        check("rst cnt_exact",  32'(cnt_exact), 32'd0);
        check("rst cnt_err",    32'(cnt_err),   32'd0);
        drive(1'b1, 8'h1A, 4'd5); step();
        drive(1'b0, 8'h00, 4'd0);
        check("post-rst root", 32'(out_root), 32'd5);
        check("post-rst rem",  32'(out_rem),  32'd1);
        out_ready = 1'b1; step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            stat_clr   = ($urandom_range(0, 49) == 0);
            in_operand = 8'($urandom_range(0, 255));
            in_root    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                                                     : 4'($clog2(int'(in_operand) + 1) > 0 ? 0 : 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int r = 15; r >= 0; r--) begin
                    if (r * r <= int'(in_operand)) begin
                        in_root = 4'(r);
                        break;
                    end
                end
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 4'd0);
        stat_clr = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt8_result_stage.md
Name: sqrt8_result_stage

Overview:
- Registered consumer stage directly downstream of the 8-bit combinational integer square-root block.
- Captures each operand/root pair with a valid/ready handshake and computes the remainder (operand − root²).
- Flags exact squares and inconsistent roots, buffers results in a small FIFO for a back-pressured sink, and keeps saturating statistics counters.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, ≥2.
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operand/root pair present.
- in_ready  output  1  stage can accept a pair this cycle.
- in_operand  input  8  radicand fed to the sqrt block.
- in_root  input  4  root produced by the sqrt block for in_operand.
- out_valid  output  1  head result available.
- out_ready  input  1  sink accepts head result.
- out_root  output  4  root of head entry.
- out_rem  output  5  remainder of head entry, 0..30.
- out_exact  output  1  head entry is a perfect square (rem == 0, no error).
- out_err  output  1  head root inconsistent with operand.
- stat_clr  input  1  synchronous clear of both statistics counters.
- cnt_exact  output  CNT_W  count of accepted exact squares, saturating.
- cnt_err  output  CNT_W  count of accepted erroneous roots, saturating.

Behaviour:
- Reset: the clock is clk; reset is rst_n, synchronous and active-low, sampled on the rising edge of clk.
- Reset state: FIFO empty, out_valid=0, in_ready=1, out_root/out_rem/out_exact/out_err=0, cnt_exact=cnt_err=0.
- Reset mid-operation discards all buffered entries. No partial result is emitted.
- Accept: a pair is accepted when in_valid && in_ready at a rising edge.
- in_ready: equals !full, derived from registered occupancy only. It has no combinational dependence on out_ready.
- Pop: occurs when out_valid && out_ready.
- Latency: an accepted pair appears at the FIFO head no earlier than the next cycle. When the FIFO was empty it appears exactly 1 cycle later, with out_valid=1.
- Arithmetic: sq = in_root*in_root (8-bit unsigned, max 225). diff = {1'b0,in_operand} − {1'b0,sq}, 9-bit.
- err=1 when diff < 0 (root too large) or diff > 2*in_root (root too small).
- On err: rem forced to 0 and exact=0. Otherwise rem = diff[4:0] and exact = (diff == 0).
- Computation is done at acceptance and stored in the FIFO entry: root 4 + rem 5 + exact 1 + err 1 = 11 bits.
- Output fields: out_* present the head entry while out_valid=1 and are held stable until popped. When empty, out_* hold 0.
- Simultaneous push and pop, not full: both occur; occupancy unchanged.
- Simultaneous push and pop, full: in_ready=0, so only the pop occurs. There is no same-cycle refill of a full FIFO.
- Simultaneous push and pop, empty: pop is impossible (out_valid=0); push proceeds.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate log2(DEPTH)+1-bit counter.
- Counters update on acceptance, not on pop. cnt_exact +1 when exact; cnt_err +1 when err. Each saturates at all-ones.
- stat_clr=1 zeroes both counters. It takes priority over a same-cycle increment, and that increment is lost.
- in_operand/in_root are ignored when in_valid=0.
- No X propagation: all flops are reset.

Decomposition:
- Shared package sqrt8_pkg holds:
  - constants OPND_W=8, ROOT_W=4, REM_W=5;
  - the packed struct type for a result entry {root, rem, exact, err};
  - a function computing {rem, exact, err} from operand and root.
- One sub-module, sqrt8_result_fifo: a parameterised DEPTH-entry synchronous FIFO of the entry type with full/empty outputs, reset via rst_n.
- Remainder logic and counters stay in the top module.

Test Plan:
- operand 0xFF, root 0xF → 1 cycle later out_valid=1, out_root=15, out_rem=30, out_exact=0, out_err=0.
- operand 0x40, root 8 → out_rem=0, out_exact=1; cnt_exact=1 after acceptance.
- operand 0x10, root 5 → out_err=1, out_rem=0, out_exact=0. Also operand 0x23, root 4 (diff 19>8) → out_err=1. Then cnt_err=2.
- Back-pressure: out_ready=0, push 3 pairs back-to-back → 2 accepted, in_ready=0 on cycle 3. With out_ready=1, one pop per cycle in order, then in_ready reasserts.
- 255 exact squares then 2 more with CNT_W=8 → cnt_exact holds 255. stat_clr in the same cycle as an exact accept → cnt_exact=0.
- FIFO holding 2 entries, rst_n=0 for one cycle → next cycle out_valid=0, in_ready=1, counters 0. A subsequent pair emerges with correct fields.
